// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding and small helpers for the VGA receive monitor.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    // Coordinates and line counts stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc16_step.sv
// One CRC-16-CCITT update over a full 16-bit word, MSB first, no reflection.
module crc16_step
    import vga_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [15:0] data,
    output logic [15:0] crc_next
);

    logic [15:0] acc;

    always_comb begin
        acc = crc;
        for (int i = 15; i >= 0; i--) begin
            if (acc[15] ^ data[i]) begin
                acc = {acc[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                acc = {acc[14:0], 1'b0};
            end
        end
        crc_next = acc;
    end

endmodule

// File: rtl/vga_rx_monitor.sv
// Recovers pixel coordinates from a DE-framed VGA stream, measures its timing,
// signs each frame with a CRC and tracks lock against the expected geometry.
module vga_rx_monitor
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        pix_clk,
    input  logic        pix_rstn,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        vga_de,
    input  logic [4:0]  vga_r,
    input  logic [5:0]  vga_g,
    input  logic [4:0]  vga_b,
    output logic [15:0] rx_x,
    output logic [15:0] rx_y,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        frame_done,
    output logic [15:0] frame_crc,
    output logic [15:0] meas_h,
    output logic [15:0] meas_v,
    output logic        locked,
    output logic [7:0]  err_cnt
);

    localparam logic [15:0] H_EXP = 16'(H_ACTIVE);
    localparam logic [15:0] V_EXP = 16'(V_ACTIVE);

    logic        hs_q, vs_q, de_q, vs_d, de_d;
    logic [15:0] rgb_q;
    logic        unused_hsync;

    logic        vs_act, vs_act_d, vs_edge, de_rise, de_fall;
    logic [15:0] line_len, lines_now;
    logic        len_err, sync_de_err, line_err, count_err, frame_bad;

    logic [15:0] crc_run, crc_step;
    logic        frame_err, seen_edge;

    mon_state_t  state, state_next;
    logic        err_event;

    // Sync levels reset to their idle value so release cannot fake a vsync edge.
    always_ff @(posedge pix_clk) begin
        if (!pix_rstn) begin
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            vs_d  <= ~SYNC_POL;
            de_q  <= 1'b0;
            de_d  <= 1'b0;
            rgb_q <= 16'h0000;
        end else begin
            hs_q  <= vga_hsync;
            vs_q  <= vga_vsync;
            de_q  <= vga_de;
            rgb_q <= {vga_r, vga_g, vga_b};
            vs_d  <= vs_q;
            de_d  <= de_q;
        end
    end

    // Line framing comes entirely from DE; hsync is only captured.
    assign unused_hsync = hs_q;

    assign vs_act   = (vs_q == SYNC_POL);
    assign vs_act_d = (vs_d == SYNC_POL);
    assign vs_edge  = vs_act & ~vs_act_d;
    assign de_rise  = de_q & ~de_d;
    assign de_fall  = ~de_q & de_d;

    assign line_len  = sat_inc16(rx_x);
    assign lines_now = de_fall ? sat_inc16(rx_y) : rx_y;

    // A burst of DE inside vsync is reported once, not again as a short line.
    assign len_err     = de_fall & ~vs_act & (line_len != H_EXP);
    assign sync_de_err = de_q & vs_act & ~(de_d & vs_act_d);
    assign line_err    = len_err | sync_de_err;
    assign count_err   = vs_edge & (lines_now != V_EXP);
    assign frame_bad   = frame_err | line_err;

    crc16_step u_crc (
        .crc      (crc_run),
        .data     (rgb_q),
        .crc_next (crc_step)
    );

    // The first vsync edge after reset only opens a frame; nothing is reported for it.
    always_ff @(posedge pix_clk) begin
        if (!pix_rstn) begin
            rx_x       <= 16'h0000;
            rx_y       <= 16'h0000;
            pix_valid  <= 1'b0;
            pix_data   <= 16'h0000;
            meas_h     <= 16'h0000;
            meas_v     <= 16'h0000;
            frame_crc  <= CRC_INIT;
            crc_run    <= CRC_INIT;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            seen_edge  <= 1'b0;
        end else begin
            pix_valid  <= de_q;
            frame_done <= 1'b0;
            if (de_q) begin
                rx_x     <= de_rise ? 16'h0000 : sat_inc16(rx_x);
                pix_data <= rgb_q;
            end
            if (de_fall) begin
                meas_h <= line_len;
            end
            if (vs_edge) begin
                rx_y      <= 16'h0000;
                frame_err <= 1'b0;
                crc_run   <= CRC_INIT;
                seen_edge <= 1'b1;
                if (seen_edge) begin
                    meas_v     <= lines_now;
                    frame_crc  <= crc_run;
                    frame_done <= (lines_now != 16'h0000);
                end
            end else begin
                rx_y <= lines_now;
                if (line_err) begin
                    frame_err <= 1'b1;
                end
                if (de_q) begin
                    crc_run <= crc_step;
                end
            end
        end
    end

    always_ff @(posedge pix_clk) begin
        if (!pix_rstn) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SEARCH:  if (vs_edge) state_next = MEASURE;
            MEASURE: if (vs_edge && !frame_bad && (lines_now == V_EXP)) state_next = LOCKED;
            LOCKED:  if (line_err || count_err) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase
    end

    always_comb begin
        locked    = (state == LOCKED);
        err_event = (state == LOCKED) & (line_err | count_err);
    end

    always_ff @(posedge pix_clk) begin
        if (!pix_rstn) begin
            err_cnt <= 8'h00;
        end else if (err_event && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboard bench for vga_rx_monitor using a scaled-down 8x4 raster.
module tb_vga_rx_monitor;

    localparam int H = 8;
    localparam int V = 4;

    logic        pix_clk = 1'b0;
    logic        pix_rstn;
    logic        vga_hsync, vga_vsync, vga_de;
    logic [4:0]  vga_r;
    logic [5:0]  vga_g;
    logic [4:0]  vga_b;
    logic [15:0] rx_x, rx_y, pix_data, frame_crc, meas_h, meas_v;
    logic        pix_valid, frame_done, locked;
    logic [7:0]  err_cnt;

    vga_rx_monitor #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .SYNC_POL (1'b0)
    ) dut (
        .pix_clk    (pix_clk),
        .pix_rstn   (pix_rstn),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .vga_de     (vga_de),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .rx_x       (rx_x),
        .rx_y       (rx_y),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .frame_done (frame_done),
        .frame_crc  (frame_crc),
        .meas_h     (meas_h),
        .meas_v     (meas_v),
        .locked     (locked),
        .err_cnt    (err_cnt)
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] data;
        int          stamp;
    } pix_exp_t;

    typedef struct {
        logic [15:0] crc;
        logic [15:0] lines;
    } frame_exp_t;

    pix_exp_t    pix_q[$];
    frame_exp_t  frame_q[$];
    pix_exp_t    pe;
    frame_exp_t  fe;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [15:0] crc_model;
    logic [15:0] solid_crc;

    always @(posedge pix_clk) cyc <= cyc + 1;

    function automatic logic [15:0] crcModel(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r = c;
        for (int b = 1; b >= 0; b--) begin
            r = r ^ {d[b*8 +: 8], 8'h00};
            for (int k = 0; k < 8; k++) begin
                r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] pat(input int x, input int y);
        return 16'h3C00 ^ 16'((y * 256) + (x * 3) + 1);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Drives one pixel-clock cycle; DE cycles register their expected output.
    task automatic applyStimulus(input logic vs_on, input logic hs_on, input logic de,
                                 input logic [15:0] px, input logic [15:0] ex, input logic [15:0] ey);
        vga_vsync = ~vs_on;
        vga_hsync = ~hs_on;
        vga_de    = de;
        {vga_r, vga_g, vga_b} = de ? px : 16'h0000;
        if (de) begin
            pix_q.push_back('{x: ex, y: ey, data: px, stamp: cyc + 2});
            crc_model = crcModel(crc_model, px);
        end
        @(posedge pix_clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic sendLine(input int y, input int len, input bit solid);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, solid ? 16'hF800 : pat(i, y), 16'(i), 16'(y));
        end
        idle();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        idle();
    endtask

    task automatic sendFrame(input int y0, input bit solid);
        for (int l = 0; l < V; l++) begin
            sendLine(y0 + l, H, solid);
        end
    endtask

    // Four asserted vsync cycles; optional single DE cycle on the second one.
    task automatic vsyncPulse(input bit expect_done, input int lines, input bit stray_de);
        if (expect_done) begin
            frame_q.push_back('{crc: crc_model, lines: 16'(lines)});
        end
        crc_model = 16'hFFFF;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 1'b0, stray_de, 16'h07E0, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        idle();
        idle();
    endtask

    task automatic checkResetState();
        checkOutput("rst_pix_valid", 16'(pix_valid), 16'h0000);
        checkOutput("rst_frame_done", 16'(frame_done), 16'h0000);
        checkOutput("rst_locked", 16'(locked), 16'h0000);
        checkOutput("rst_err_cnt", 16'(err_cnt), 16'h0000);
        checkOutput("rst_rx_x", rx_x, 16'h0000);
        checkOutput("rst_rx_y", rx_y, 16'h0000);
        checkOutput("rst_pix_data", pix_data, 16'h0000);
        checkOutput("rst_meas_h", meas_h, 16'h0000);
        checkOutput("rst_meas_v", meas_v, 16'h0000);
        checkOutput("rst_frame_crc", frame_crc, 16'hFFFF);
    endtask

    // Scoreboard side: every valid pixel and every frame_done must match the queue head.
    always @(negedge pix_clk) begin
        if (pix_valid) begin
            if (pix_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL pix_unexpected: got x=%0d y=%0d expected no pixel", rx_x, rx_y);
            end else begin
                pe = pix_q.pop_front();
                checkOutput("pix_latency", 16'(cyc), 16'(pe.stamp));
                checkOutput("rx_x", rx_x, pe.x);
                checkOutput("rx_y", rx_y, pe.y);
                checkOutput("pix_data", pix_data, pe.data);
            end
        end
        if (frame_done) begin
            if (frame_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL frame_done_unexpected: got pulse expected none at cycle %0d", cyc);
            end else begin
                fe = frame_q.pop_front();
                checkOutput("frame_crc", frame_crc, fe.crc);
                checkOutput("meas_v", meas_v, fe.lines);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected end of stimulus");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        crc_model = 16'hFFFF;
        solid_crc = 16'hFFFF;
        for (int i = 0; i < H * V; i++) begin
            solid_crc = crcModel(solid_crc, 16'hF800);
        end

        pix_rstn = 1'b0;
        repeat (3) idle();
        checkResetState();
        pix_rstn = 1'b1;
        repeat (2) idle();

        $display("[TB] clean solid frames");
        vsyncPulse(1'b0, 0, 1'b0);
        sendFrame(0, 1'b1);
        vsyncPulse(1'b1, V, 1'b0);
        checkOutput("lock_after_2nd_edge", 16'(locked), 16'h0001);
        checkOutput("meas_h_clean", meas_h, 16'(H));
        checkOutput("meas_v_clean", meas_v, 16'(V));
        checkOutput("err_cnt_clean", 16'(err_cnt), 16'h0000);
        checkOutput("solid_crc_1", frame_crc, solid_crc);
        sendFrame(0, 1'b1);
        vsyncPulse(1'b1, V, 1'b0);
        checkOutput("solid_crc_2", frame_crc, solid_crc);

        $display("[TB] short line while locked");
        sendLine(0, H, 1'b0);
        sendLine(1, H - 1, 1'b0);
        checkOutput("unlock_short_line", 16'(locked), 16'h0000);
        checkOutput("err_cnt_short", 16'(err_cnt), 16'h0001);
        checkOutput("meas_h_short", meas_h, 16'(H - 1));
        sendLine(2, H, 1'b0);
        sendLine(3, H, 1'b0);
        vsyncPulse(1'b1, V, 1'b0);
        checkOutput("still_unlocked", 16'(locked), 16'h0000);
        sendFrame(0, 1'b0);
        vsyncPulse(1'b1, V, 1'b0);
        sendFrame(0, 1'b0);
        vsyncPulse(1'b1, V, 1'b0);
        checkOutput("relock", 16'(locked), 16'h0001);
        checkOutput("err_cnt_relock", 16'(err_cnt), 16'h0001);

        $display("[TB] de during vsync");
        sendFrame(0, 1'b0);
        vsyncPulse(1'b1, V, 1'b1);
        checkOutput("unlock_de_in_vsync", 16'(locked), 16'h0000);
        checkOutput("err_cnt_de_in_vsync", 16'(err_cnt), 16'h0002);
        sendFrame(1, 1'b0);
        vsyncPulse(1'b1, V + 1, 1'b0);
        sendFrame(0, 1'b0);
        vsyncPulse(1'b1, V, 1'b0);
        checkOutput("relock_after_vsync_de", 16'(locked), 16'h0001);

        $display("[TB] reset mid-frame");
        sendLine(0, H, 1'b0);
        sendLine(1, H, 1'b0);
        pix_rstn = 1'b0;
        repeat (2) idle();
        checkResetState();
        pix_rstn = 1'b1;
        crc_model = 16'hFFFF;
        sendLine(0, H, 1'b0);
        sendLine(1, H, 1'b0);
        vsyncPulse(1'b0, 0, 1'b0);
        sendFrame(0, 1'b0);
        vsyncPulse(1'b1, V, 1'b0);
        checkOutput("lock_after_reset", 16'(locked), 16'h0001);
        checkOutput("err_cnt_after_reset", 16'(err_cnt), 16'h0000);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 300; i++) begin
            vsyncPulse(1'b0, 0, 1'b0);
            checkOutput("err_cnt_sat", 16'(err_cnt), (i + 1 > 255) ? 16'd255 : 16'(i + 1));
            checkOutput("unlock_count_err", 16'(locked), 16'h0000);
            vsyncPulse(1'b0, 0, 1'b0);
            sendFrame(0, 1'b1);
            vsyncPulse(1'b1, V, 1'b0);
        end
        checkOutput("err_cnt_final", 16'(err_cnt), 16'd255);
        checkOutput("locked_final", 16'(locked), 16'h0001);

        repeat (4) idle();
        checkOutput("pix_queue_empty", 16'(pix_q.size()), 16'h0000);
        checkOutput("frame_queue_empty", 16'(frame_q.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
